mc_sequencer: RTL

Multi-cycle control sequencer for the MIPS datapath. It splits each instruction into FETCH/DECODE/EXEC/MEM/WB phases so that IM and DM can be slow memories with a request/acknowledge handshake. It drives every datapath enable and mux select: PC, IR, GRF, DM, ALU, EXT and NPC. It sits between the instruction register and the datapath, replacing the purely combinational Controller.

---
 rtl/mc_sequencer_pkg.sv | 64 ++++++
 rtl/mc_decode.sv | 58 +++++
 rtl/mc_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mc_sequencer_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
// Optional perf counters in the top are enabled by MC_SEQUENCER_PERF_EN.
package mc_sequencer_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_IMM,
        C_LOAD,
        C_STORE,
        C_BEQ,
        C_JAL,
        C_JR,
        C_ILL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_LUI  = 3'd3;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JAL  = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [1:0] A3_RD    = 2'b00;
    localparam logic [1:0] A3_RT    = 2'b01;
    localparam logic [1:0] A3_RA    = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    typedef struct packed {
        iclass_t    cls;
        logic [2:0] alu_op;
        logic       alu_b;
        logic       ext_signed;
        logic       is_lb;
    } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/func to class plus static
// datapath controls that hold for the whole instruction.
module mc_decode
    import mc_sequencer_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '{cls: C_ILL, alu_op: ALU_ADD, alu_b: 1'b0,
                 ext_signed: 1'b0, is_lb: 1'b0};
        unique case (1'b1)
            (op == OP_RTYPE && func == FN_ADDU): begin
                ctrl.cls = C_RTYPE;
            end
            (op == OP_RTYPE && func == FN_SUBU): begin
                ctrl.cls    = C_RTYPE;
                ctrl.alu_op = ALU_SUB;
            end
            (op == OP_RTYPE && func == FN_JR): begin
                ctrl.cls = C_JR;
            end
            (op == OP_ORI): begin
                ctrl.cls    = C_IMM;
                ctrl.alu_op = ALU_OR;
                ctrl.alu_b  = 1'b1;
            end
            (op == OP_LUI): begin
                ctrl.cls    = C_IMM;
                ctrl.alu_op = ALU_LUI;
                ctrl.alu_b  = 1'b1;
            end
            (op == OP_LW), (op == OP_LB): begin
                ctrl.cls        = C_LOAD;
                ctrl.alu_b      = 1'b1;
                ctrl.ext_signed = 1'b1;
                ctrl.is_lb      = (op == OP_LB);
            end
            (op == OP_SW): begin
                ctrl.cls        = C_STORE;
                ctrl.alu_b      = 1'b1;
                ctrl.ext_signed = 1'b1;
            end
            (op == OP_BEQ): begin
                ctrl.cls        = C_BEQ;
                ctrl.alu_op     = ALU_SUB;
                ctrl.ext_signed = 1'b1;
            end
            (op == OP_JAL): begin
                ctrl.cls = C_JAL;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with IM/DM handshakes.
// Define MC_SEQUENCER_PERF_EN to add cycle_cnt/instr_cnt outputs.
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter bit DECODE_ILLEGAL_TRAP = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        is_equal,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        grf_we,
    output logic        dm_we,
    output logic [1:0]  a3_sel,
    output logic [1:0]  wd_sel,
    output logic        alu_b,
    output logic        ext_signed,
    output logic [2:0]  alu_op,
    output logic [1:0]  npc_sel,
    output logic        is_lb,
    output logic        illegal
`ifdef MC_SEQUENCER_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_t state;
    ctrl_t  ctrl;

    mc_decode u_decode (
        .op   (op),
        .func (func),
        .ctrl (ctrl)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            unique case (state)
                FETCH:  if (imem_ack) state <= DECODE;
                DECODE: begin
                    if (ctrl.cls == C_ILL && DECODE_ILLEGAL_TRAP)
                        state <= HALT;
                    else
                        state <= EXEC;
                end
                EXEC: begin
                    unique case (ctrl.cls)
                        C_RTYPE, C_IMM:  state <= WB;
                        C_LOAD, C_STORE: state <= MEM;
                        default:         state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (dmem_ack)
                        state <= (ctrl.cls == C_STORE) ? FETCH : WB;
                end
                WB:      state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Everything is a decode of state and IR; only ir_we and the store
    // pc_we look at an ack. The reset cycle forces every output low.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        grf_we     = 1'b0;
        dm_we      = 1'b0;
        a3_sel     = A3_RD;
        wd_sel     = WD_ALU;
        alu_b      = 1'b0;
        ext_signed = 1'b0;
        alu_op     = ALU_ADD;
        npc_sel    = NPC_PC4;
        is_lb      = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            if (state == EXEC || state == MEM || state == WB) begin
                alu_op     = ctrl.alu_op;
                alu_b      = ctrl.alu_b;
                ext_signed = ctrl.ext_signed;
            end
            unique case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                DECODE: illegal = (ctrl.cls == C_ILL);
                EXEC: begin
                    unique case (ctrl.cls)
                        C_BEQ: begin
                            pc_we   = 1'b1;
                            npc_sel = is_equal ? NPC_BR : NPC_PC4;
                        end
                        C_JAL: begin
                            pc_we   = 1'b1;
                            grf_we  = 1'b1;
                            a3_sel  = A3_RA;
                            wd_sel  = WD_PC4;
                            npc_sel = NPC_JAL;
                        end
                        C_JR: begin
                            pc_we   = 1'b1;
                            npc_sel = NPC_JR;
                        end
                        C_ILL:   pc_we = 1'b1;
                        default: ;
                    endcase
                end
                MEM: begin
                    dmem_req = 1'b1;
                    is_lb    = ctrl.is_lb;
                    dm_we    = (ctrl.cls == C_STORE);
                    pc_we    = (ctrl.cls == C_STORE) && dmem_ack;
                end
                WB: begin
                    grf_we = 1'b1;
                    pc_we  = 1'b1;
                    is_lb  = ctrl.is_lb;
                    wd_sel = (ctrl.cls == C_LOAD) ? WD_DM : WD_ALU;
                    a3_sel = (ctrl.cls == C_RTYPE) ? A3_RD : A3_RT;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_SEQUENCER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_we)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule
